// File: rtl/xip_pkg.sv
// Shared definitions for the XIP prefetch buffer: FSM states, AXI response codes, line index width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package xip_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL_AR = 2'd1,
    FILL_R  = 2'd2,
    RESP    = 2'd3
  } xip_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of address bits needed to select a word within a line.
  function automatic int line_idx_w(input int words);
    int w;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      if ((1 << i) < words) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/xip_line_ram.sv
// Line storage: WORDS x 32, one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none, always accepts writes.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module xip_line_ram #(
  parameter int WORDS = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/xip_prefetch_buf.sv
// Single-line read prefetch buffer between an AXI-Lite master and the xip_engine slave.
// Latency: hit returns data 1 cycle after AR; miss issues first downstream AR 1 cycle after AR, then fetches the whole line.
// Backpressure: one request at a time; s_arready only in IDLE, s_rvalid/s_rdata held until s_rready.
// Ports: clk, reset (async active-high), invalidate_i, s_ar*/s_r* upstream, m_ar*/m_r* downstream,
//        busy_o, and hit_cnt_o/miss_cnt_o when XIP_PF_STATS_EN is defined.
module xip_prefetch_buf
  import xip_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        invalidate_i,
  input  logic [31:0] s_araddr_i,
  input  logic        s_arvalid_i,
  output logic        s_arready_o,
  output logic [31:0] s_rdata_o,
  output logic [1:0]  s_rresp_o,
  output logic        s_rvalid_o,
  input  logic        s_rready_i,
  output logic [31:0] m_araddr_o,
  output logic        m_arvalid_o,
  input  logic        m_arready_i,
  input  logic [31:0] m_rdata_i,
  input  logic [1:0]  m_rresp_i,
  input  logic        m_rvalid_i,
  output logic        m_rready_o,
`ifdef XIP_PF_STATS_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  output logic        busy_o
);

  localparam int IDX_W = line_idx_w(LINE_WORDS);
  localparam int TAG_W = 30 - IDX_W;

  xip_state_e       state;
  logic [TAG_W-1:0] tag;
  logic             line_valid;
  logic             err;
  logic             inval_seen;  // invalidate seen while a fill was in flight
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] k_inc;
  logic [IDX_W-1:0] sel;         // word index of the pending request

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             ar_hs;
  logic             lookup_hit;
  logic             err_next;
  logic             last_beat;
  logic [31:0]      ram_rdata;
  logic             unused_addr_lsb;

  assign req_tag    = s_araddr_i[31:2+IDX_W];
  assign req_idx    = s_araddr_i[2+IDX_W-1:2];
  assign ar_hs      = (state == IDLE) && s_arvalid_i;
  // An invalidate coinciding with the lookup forces a miss.
  assign lookup_hit = line_valid && (tag == req_tag) && !invalidate_i;
  assign err_next   = err | (|m_rresp_i);
  assign last_beat  = (k == IDX_W'(LINE_WORDS - 1));
  assign k_inc      = k + 1'b1;
  assign unused_addr_lsb = ^s_araddr_i[1:0];

  // Handshake signals are pure decodes of the state register.
  assign s_arready_o = (state == IDLE);
  assign s_rvalid_o  = (state == RESP);
  assign m_arvalid_o = (state == FILL_AR);
  assign m_rready_o  = (state == FILL_R);
  assign busy_o      = (state != IDLE);

  xip_line_ram #(
    .WORDS (LINE_WORDS),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    ((state == FILL_R) && m_rvalid_i),
    .waddr (k),
    .wdata (m_rdata_i),
    .raddr (req_idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tag        <= '0;
      line_valid <= 1'b0;
      err        <= 1'b0;
      inval_seen <= 1'b0;
      k          <= '0;
      sel        <= '0;
      s_rdata_o  <= '0;
      s_rresp_o  <= RESP_OKAY;
      m_araddr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (invalidate_i) line_valid <= 1'b0;
          if (ar_hs) begin
            sel <= req_idx;
            if (lookup_hit) begin
              state     <= RESP;
              s_rdata_o <= ram_rdata;
              s_rresp_o <= RESP_OKAY;
            end else begin
              state      <= FILL_AR;
              line_valid <= 1'b0;
              tag        <= req_tag;
              k          <= '0;
              err        <= 1'b0;
              inval_seen <= 1'b0;
              m_araddr_o <= {req_tag, {IDX_W{1'b0}}, 2'b00};
            end
          end
        end
        FILL_AR: begin
          if (invalidate_i) inval_seen <= 1'b1;
          if (m_arready_i) state <= FILL_R;
        end
        FILL_R: begin
          if (invalidate_i) inval_seen <= 1'b1;
          if (m_rvalid_i) begin
            err <= err_next;
            // Capture the requested word as it streams past.
            if (k == sel) s_rdata_o <= m_rdata_i;
            if (last_beat) begin
              state      <= RESP;
              k          <= '0;
              line_valid <= !err_next && !inval_seen && !invalidate_i;
              s_rresp_o  <= err_next ? RESP_SLVERR : RESP_OKAY;
            end else begin
              state      <= FILL_AR;
              k          <= k_inc;
              m_araddr_o <= {tag, k_inc, 2'b00};
            end
          end
        end
        RESP: begin
          if (invalidate_i) line_valid <= 1'b0;
          if (s_rready_i) begin
            state <= IDLE;
            err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XIP_PF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (ar_hs) begin
      if (lookup_hit) begin
        if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/xip_prefetch_buf.md
XIP_PREFETCH_BUF -- requirements
Module: xip_prefetch_buf

Interface
- REQ-001: Parameter LINE_WORDS, default 4, 32-bit words per buffered line; SHALL be a power of two in the range 2..16.
- REQ-002: Port clk, input, 1, the single clock; all logic SHALL be rising-edge.
- REQ-003: Port reset, input, 1, asynchronous active-high reset.
- REQ-004: Port invalidate_i, input, 1, drops the buffered line.
- REQ-005: Ports s_araddr_i (in, 32), s_arvalid_i (in, 1), s_arready_o (out, 1): upstream AXI-Lite read address.
- REQ-006: Ports s_rdata_o (out, 32), s_rresp_o (out, 2), s_rvalid_o (out, 1), s_rready_i (in, 1): upstream read data.
- REQ-007: Ports m_araddr_o (out, 32), m_arvalid_o (out, 1), m_arready_i (in, 1): downstream read address to the xip_engine AXI-Lite slave.
- REQ-008: Ports m_rdata_i (in, 32), m_rresp_i (in, 2), m_rvalid_i (in, 1), m_rready_o (out, 1): downstream read data from the xip_engine.
- REQ-009: Port busy_o, out, 1, high in any state other than IDLE.

Function
- REQ-010: The block SHALL implement states IDLE, FILL_AR, FILL_R and RESP.
- REQ-011: s_arready_o SHALL be high only in IDLE; an AR handshake SHALL latch s_araddr_i, and bits [1:0] SHALL be ignored.
- REQ-012: A hit SHALL be line_valid and tag equal to addr[31:2+log2(LINE_WORDS)]. On a hit, the state SHALL be RESP and s_rvalid_o SHALL be high on the cycle after the AR handshake, with s_rresp_o=2'b00.
- REQ-013: On a miss, the block SHALL enter FILL_AR with k=0, clear line_valid and load the new tag.
- REQ-014: In FILL_AR, m_arvalid_o SHALL be 1 and m_araddr_o SHALL be {tag, k, 2'b00}; both SHALL be held stable until m_arready_i, after which the state SHALL be FILL_R.
- REQ-015: In FILL_R, m_rready_o SHALL be 1. On m_rvalid_i, word k SHALL be stored, m_rresp_i SHALL be OR-ed into a sticky err flag, and k SHALL increment. The state SHALL return to FILL_AR while k<LINE_WORDS-1, and otherwise go to RESP.
- REQ-016: At most one downstream AR SHALL be outstanding, and words SHALL be fetched in ascending order from word 0.
- REQ-017: On fill completion, line_valid SHALL be set only if err=0 and no invalidate occurred during the fill.
- REQ-018: In RESP, s_rdata_o SHALL be the requested word and s_rresp_o SHALL be 2'b10 if err=1 on this fill, else 2'b00. s_rvalid_o and s_rdata_o SHALL be held until s_rready_i; the state SHALL then return to IDLE and err SHALL clear.
- REQ-019: A downstream error SHALL NOT abort the fill; all LINE_WORDS beats SHALL still be fetched.
- REQ-020: invalidate_i in IDLE or RESP SHALL clear line_valid on the next edge. If asserted together with an AR handshake, that lookup SHALL be treated as a miss.
- REQ-021: m_arvalid_o and m_rready_o SHALL be 0 outside FILL_AR and FILL_R respectively.
- REQ-022: Hit latency SHALL be 1 cycle from the AR handshake to s_rvalid_o. Miss latency SHALL be 1 cycle to the first m_arvalid_o plus downstream time.

Reset
- REQ-023: Reset SHALL force the state to IDLE, line_valid=0, err=0, k=0, all valid outputs=0, s_rdata_o=0, s_rresp_o=0, m_araddr_o=0 and busy_o=0.
- REQ-024: Reset mid-fill SHALL abandon the transaction immediately; the downstream is reset together with this block.

Configuration
- REQ-025: With XIP_PF_STATS_EN defined, the block SHALL add outputs hit_cnt_o[31:0] and miss_cnt_o[31:0]. Each SHALL increment by one per AR handshake of its type, saturate at 32'hFFFF_FFFF and clear on reset.
- REQ-026: Without XIP_PF_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-027: The shared package xip_pkg SHALL hold the state enumeration, the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants, and the line-index width function.
- REQ-028: Line storage SHALL be the sub-module xip_line_ram: LINE_WORDS x 32, one synchronous write port and one asynchronous read port.

Verification
- REQ-029: Read 0x0000_0000 after reset: 4 downstream ARs at 0x0, 0x4, 0x8 and 0xC, then s_rdata_o equals device word 0 with rresp 00; miss_cnt=1.
- REQ-030: Then read 0x0000_0008: no downstream AR, and s_rvalid_o rises 1 cycle after the handshake with device word 2; hit_cnt=1.
- REQ-031: Read 0x0000_0013: miss; fill at 0x10 through 0x1C, returns word 0x10.
- REQ-032: Downstream returns rresp 2'b10 on beat 1: all 4 beats are still fetched and s_rresp_o=10; a repeat read of the same address misses again.
- REQ-033: Assert invalidate_i during FILL_R: the current read completes with correct data, and the next same-line read misses.
- REQ-034: Assert reset while m_arvalid_o=1: all outputs drop on the reset edge, and a post-reset read of the same address misses.
